mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multicycle instruction-sequencing controller for the single-datapath MIPS-subset CPU.
- Steps each instruction through IF/ID/EXE/MEM/WB states and drives every datapath control strobe: PC, IR, register file, ALU, data RAM and the write-back muxes.
- Replaces the per-opcode combinational control with a state machine so that each instruction takes only the cycles it needs.
- Inputs are the IR opcode and ALU zero flag; outputs drive the datapath directly.

Parameters:
- OP_W, 6, opcode width (instruction[31:26]).
- STATE_W, 4, width of the state register and of the debug state output.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OP_W  current IR opcode.
- zero  in  1  ALU zero flag, valid in EXE.
- PCWre  out  1  PC load enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction ROM R/W; constant 0 (read).
- RegWre  out  1  register file write enable.
- RegOut  out  2  dest select: 00=$31, 01=rt, 10=rd.
- WrRegData  out  1  0=PC+4, 1=ALU/mem path.
- ALUSrcB  out  1  0=B register, 1=extended immediate.
- ALUOp  out  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 sltu, 110 slt.
- ExtSel  out  2  00 zero-extend shamt, 01 zero-extend imm16, 10 sign-extend imm16.
- ALUM2Reg  out  1  0=ALU result, 1=data RAM output.
- DataMemRW  out  1  1=write data RAM.
- PCSrc  out  2  00 PC+4, 01 branch offset, 10 rs, 11 jump target.
- illegal  out  1  one-cycle pulse in ID on an undefined opcode.
- state  out  STATE_W  current state, for debug.

Behaviour:
- Opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, sltu 100111, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
- State encoding: IF=0, ID=1, EXE_AL=2, EXE_BR=3, EXE_LS=4, MEM=5, WB_AL=6, WB_LD=7, HALT=8.
- Outputs are combinational from (state, opcode, zero). Every output is 0 in any state where it is not listed below.
- While rst_n=0: state=IF and all outputs are forced to 0. Reset asserted mid-instruction aborts it; no write strobe may be asserted during reset.
- IF: IRWre=1 -> ID.
- ID, j: PCWre=1, PCSrc=11 -> IF.
- ID, jr: PCWre=1, PCSrc=10 -> IF.
- ID, jal: RegWre=1, RegOut=00, WrRegData=0, PCWre=1, PCSrc=11 -> IF.
- ID, halt -> HALT.
- ID, beq -> EXE_BR. ID, lw/sw -> EXE_LS. ID, R-type/immediate ALU -> EXE_AL.
- ID, undefined opcode: illegal=1, PCWre=1, PCSrc=00 -> IF (executes as a NOP).
- EXE_AL: ALUOp/ALUSrcB/ExtSel per opcode; immediates set ALUSrcB=1; ori uses ExtSel=01; addi uses ExtSel=10; sll uses ALUSrcB=1, ExtSel=00 -> WB_AL.
- WB_AL: the EXE_AL controls are held, plus RegWre=1, WrRegData=1, ALUM2Reg=0, RegOut=01 for immediates and 10 for R-type, PCWre=1, PCSrc=00 -> IF.
- EXE_BR: ALUOp=001, ExtSel=10, PCWre=1, PCSrc = zero ? 01 : 00 -> IF. zero is sampled in this same cycle.
- EXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=10 -> MEM.
- MEM, sw: DataMemRW=1, PCWre=1, PCSrc=00 -> IF.
- MEM, lw: ALUM2Reg=1 -> WB_LD.
- WB_LD: ALUM2Reg=1, RegWre=1, WrRegData=1, RegOut=01, PCWre=1, PCSrc=00 -> IF.
- HALT: all outputs 0; remains in HALT until reset.
- Latency in cycles: j/jr/jal 2, beq 3, ALU ops 4, sw 4, lw 5.
- PCWre is asserted exactly once per instruction, in its final cycle. IRWre is asserted only in IF.
- opcode is stable from ID onward because IR loads only in IF.
- Unused state codes (9-15) -> IF with all outputs 0.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[31:0] and inst_cnt[31:0].
  - cycle_cnt increments every clock while state!=HALT.
  - inst_cnt increments on each cycle where PCWre=1.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent; FSM behaviour is identical.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode localparams;
  - state enum/encoding;
  - ALUOp, PCSrc, RegOut and ExtSel code constants, shared with the ALU and selector blocks.
- One natural sub-module: mc_ctrl_decode, the combinational (state, opcode, zero) -> control-vector decode. mc_ctrl_fsm keeps the state register and next-state logic.

Test Plan:
- Reset pulse mid-EXE_LS (lw) -> state=0, all outputs 0 during reset; first cycle after release has IRWre=1 and no DataMemRW/RegWre.
- add (000000) -> states 0,1,2,6; in WB_AL RegWre=1, RegOut=10, ALUOp=000, PCWre=1; PCWre seen once in 4 cycles.
- lw (110001) then sw (110000) -> lw takes 5 cycles with ALUM2Reg=1 in MEM and WB_LD; sw takes 4 cycles with DataMemRW=1 only in MEM.
- beq with zero=1, then with zero=0 -> EXE_BR gives PCSrc=01, then 00; 3 cycles each.
- jal (111010) -> ID gives RegWre=1, RegOut=00, WrRegData=0, PCSrc=11, then back to IF.
- Opcode 101010, then halt (111111) -> illegal pulses for 1 cycle and PC advances; halt holds state=8 for 20 cycles with PCWre=0, and with MC_PERF_CNT_EN cycle_cnt is frozen.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared opcodes, state encoding and control-field codes for the multicycle controller,
// the ALU and the datapath selectors.
package mc_ctrl_pkg;

  localparam int OPC_W = 6;

  localparam logic [OPC_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OPC_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OPC_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [OPC_W-1:0] OP_OR   = 6'b010000;
  localparam logic [OPC_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OPC_W-1:0] OP_ORI  = 6'b010010;
  localparam logic [OPC_W-1:0] OP_SLL  = 6'b011000;
  localparam logic [OPC_W-1:0] OP_SLTU = 6'b100111;
  localparam logic [OPC_W-1:0] OP_SLT  = 6'b100110;
  localparam logic [OPC_W-1:0] OP_SW   = 6'b110000;
  localparam logic [OPC_W-1:0] OP_LW   = 6'b110001;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OPC_W-1:0] OP_J    = 6'b111000;
  localparam logic [OPC_W-1:0] OP_JR   = 6'b111001;
  localparam logic [OPC_W-1:0] OP_JAL  = 6'b111010;
  localparam logic [OPC_W-1:0] OP_HALT = 6'b111111;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_BR = 4'd3,
    S_EXE_LS = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_RS  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  localparam logic [1:0] RO_RA = 2'b00;
  localparam logic [1:0] RO_RT = 2'b01;
  localparam logic [1:0] RO_RD = 2'b10;

  localparam logic [1:0] EXT_SHAMT = 2'b00;
  localparam logic [1:0] EXT_ZIMM  = 2'b01;
  localparam logic [1:0] EXT_SIMM  = 2'b10;

  typedef struct packed {
    logic       pc_wre;
    logic       ir_wre;
    logic       reg_wre;
    logic [1:0] reg_out;
    logic       wr_reg_data;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] ext_sel;
    logic       alum2reg;
    logic       data_mem_rw;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic [2:0] op;
    logic       src_b;
    logic [1:0] ext;
  } alu_cfg_t;

  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
      OP_ORI, OP_SLL, OP_SLTU, OP_SLT: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic is_imm_op(input logic [OPC_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_ORI);
  endfunction

  // ALU operation, B-operand source and extender mode for the ALU-class opcodes
  function automatic alu_cfg_t alu_cfg(input logic [OPC_W-1:0] op);
    alu_cfg_t cfg;
    cfg = '{op: ALU_ADD, src_b: 1'b0, ext: EXT_SHAMT};
    case (op)
      OP_SUB:  cfg.op = ALU_SUB;
      OP_ADDI: cfg = '{op: ALU_ADD, src_b: 1'b1, ext: EXT_SIMM};
      OP_OR:   cfg.op = ALU_OR;
      OP_AND:  cfg.op = ALU_AND;
      OP_ORI:  cfg = '{op: ALU_OR, src_b: 1'b1, ext: EXT_ZIMM};
      OP_SLL:  cfg = '{op: ALU_SLL, src_b: 1'b1, ext: EXT_SHAMT};
      OP_SLTU: cfg.op = ALU_SLTU;
      OP_SLT:  cfg.op = ALU_SLT;
      default: cfg.op = ALU_ADD;
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational (state, opcode, zero) -> datapath control vector.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t           i_state,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic             i_zero,
  output ctrl_t            o_ctrl
);

  alu_cfg_t w_alu;

  assign w_alu = alu_cfg(i_opcode);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_IF: o_ctrl.ir_wre = 1'b1;
      S_ID: begin
        case (i_opcode)
          OP_J: begin
            o_ctrl.pc_wre = 1'b1;
            o_ctrl.pc_src = PC_JMP;
          end
          OP_JR: begin
            o_ctrl.pc_wre = 1'b1;
            o_ctrl.pc_src = PC_RS;
          end
          OP_JAL: begin
            o_ctrl.reg_wre     = 1'b1;
            o_ctrl.reg_out     = RO_RA;
            o_ctrl.wr_reg_data = 1'b0;
            o_ctrl.pc_wre      = 1'b1;
            o_ctrl.pc_src      = PC_JMP;
          end
          OP_HALT, OP_BEQ, OP_LW, OP_SW: ;
          default: begin
            // undefined opcodes retire as a NOP in ID
            if (!is_alu_op(i_opcode)) begin
              o_ctrl.illegal = 1'b1;
              o_ctrl.pc_wre  = 1'b1;
              o_ctrl.pc_src  = PC_SEQ;
            end
          end
        endcase
      end
      S_EXE_AL: begin
        o_ctrl.alu_op    = w_alu.op;
        o_ctrl.alu_src_b = w_alu.src_b;
        o_ctrl.ext_sel   = w_alu.ext;
      end
      S_WB_AL: begin
        o_ctrl.alu_op      = w_alu.op;
        o_ctrl.alu_src_b   = w_alu.src_b;
        o_ctrl.ext_sel     = w_alu.ext;
        o_ctrl.reg_wre     = 1'b1;
        o_ctrl.wr_reg_data = 1'b1;
        o_ctrl.reg_out     = is_imm_op(i_opcode) ? RO_RT : RO_RD;
        o_ctrl.pc_wre      = 1'b1;
        o_ctrl.pc_src      = PC_SEQ;
      end
      S_EXE_BR: begin
        o_ctrl.alu_op  = ALU_SUB;
        o_ctrl.ext_sel = EXT_SIMM;
        o_ctrl.pc_wre  = 1'b1;
        o_ctrl.pc_src  = i_zero ? PC_BR : PC_SEQ;
      end
      S_EXE_LS: begin
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.alu_src_b = 1'b1;
        o_ctrl.ext_sel   = EXT_SIMM;
      end
      S_MEM: begin
        if (i_opcode == OP_SW) begin
          o_ctrl.data_mem_rw = 1'b1;
          o_ctrl.pc_wre      = 1'b1;
          o_ctrl.pc_src      = PC_SEQ;
        end else begin
          o_ctrl.alum2reg = 1'b1;
        end
      end
      S_WB_LD: begin
        o_ctrl.alum2reg    = 1'b1;
        o_ctrl.reg_wre     = 1'b1;
        o_ctrl.wr_reg_data = 1'b1;
        o_ctrl.reg_out     = RO_RT;
        o_ctrl.pc_wre      = 1'b1;
        o_ctrl.pc_src      = PC_SEQ;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle instruction-sequencing controller: state register, next-state logic, output gating.
// Optional MC_PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               zero,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               RegWre,
  output logic [1:0]         RegOut,
  output logic               WrRegData,
  output logic               ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic [1:0]         ExtSel,
  output logic               ALUM2Reg,
  output logic               DataMemRW,
  output logic [1:0]         PCSrc,
  output logic               illegal,
  output logic [STATE_W-1:0] state
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        inst_cnt
`endif
);

  state_t r_state;
  state_t w_state_next;
  ctrl_t  w_ctrl;
  ctrl_t  w_ctrl_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IF;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = S_IF;
    case (r_state)
      S_IF: w_state_next = S_ID;
      S_ID: begin
        case (opcode)
          OP_J, OP_JR, OP_JAL: w_state_next = S_IF;
          OP_HALT:             w_state_next = S_HALT;
          OP_BEQ:              w_state_next = S_EXE_BR;
          OP_LW, OP_SW:        w_state_next = S_EXE_LS;
          default:             w_state_next = is_alu_op(opcode) ? S_EXE_AL : S_IF;
        endcase
      end
      S_EXE_AL: w_state_next = S_WB_AL;
      S_EXE_LS: w_state_next = S_MEM;
      S_MEM:    w_state_next = (opcode == OP_SW) ? S_IF : S_WB_LD;
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_IF;
    endcase
  end

  mc_ctrl_decode u_decode (
    .i_state  (r_state),
    .i_opcode (opcode),
    .i_zero   (zero),
    .o_ctrl   (w_ctrl)
  );

  // no strobe may reach the datapath while reset is held
  assign w_ctrl_out = rst_n ? w_ctrl : '0;

  assign PCWre     = w_ctrl_out.pc_wre;
  assign IRWre     = w_ctrl_out.ir_wre;
  assign InsMemRW  = 1'b0;
  assign RegWre    = w_ctrl_out.reg_wre;
  assign RegOut    = w_ctrl_out.reg_out;
  assign WrRegData = w_ctrl_out.wr_reg_data;
  assign ALUSrcB   = w_ctrl_out.alu_src_b;
  assign ALUOp     = w_ctrl_out.alu_op;
  assign ExtSel    = w_ctrl_out.ext_sel;
  assign ALUM2Reg  = w_ctrl_out.alum2reg;
  assign DataMemRW = w_ctrl_out.data_mem_rw;
  assign PCSrc     = w_ctrl_out.pc_src;
  assign illegal   = w_ctrl_out.illegal;
  assign state     = STATE_W'(r_state);

`ifdef MC_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_inst_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_ctrl.pc_wre)     r_inst_cnt  <= r_inst_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign inst_cnt  = r_inst_cnt;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized instruction stream checked cycle-by-cycle against a per-instruction control schedule.
module tb_mc_ctrl_fsm;

  localparam logic [5:0] T_ADD = 6'b000000, T_SUB = 6'b000001, T_ADDI = 6'b000010;
  localparam logic [5:0] T_OR = 6'b010000, T_AND = 6'b010001, T_ORI = 6'b010010;
  localparam logic [5:0] T_SLL = 6'b011000, T_SLTU = 6'b100111, T_SLT = 6'b100110;
  localparam logic [5:0] T_SW = 6'b110000, T_LW = 6'b110001, T_BEQ = 6'b110100;
  localparam logic [5:0] T_J = 6'b111000, T_JR = 6'b111001, T_JAL = 6'b111010;
  localparam logic [5:0] T_HALT = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, imrw, regw;
    logic [1:0] ro;
    logic       wrd, srcb;
    logic [2:0] aop;
    logic [1:0] ext;
    logic       m2r, dmw;
    logic [1:0] psrc;
    logic       ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [5:0] opcode = '0;
  logic zero = 1'b0;
  logic PCWre, IRWre, InsMemRW, RegWre, WrRegData, ALUSrcB, ALUM2Reg, DataMemRW, illegal;
  logic [1:0] RegOut, ExtSel, PCSrc;
  logic [2:0] ALUOp;
  logic [3:0] state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, inst_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int n_inst = 0;
  vec_t exp_q[$];
  logic [5:0] legal_ops [15] = '{T_ADD, T_SUB, T_ADDI, T_OR, T_AND, T_ORI, T_SLL, T_SLTU,
                                 T_SLT, T_SW, T_LW, T_BEQ, T_J, T_JR, T_JAL};

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
    .RegOut(RegOut), .WrRegData(WrRegData), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ExtSel(ExtSel), .ALUM2Reg(ALUM2Reg), .DataMemRW(DataMemRW), .PCSrc(PCSrc),
    .illegal(illegal), .state(state)
`ifdef MC_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
`endif
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic vec_t observed();
    vec_t v;
    v = '{st: state, pcw: PCWre, irw: IRWre, imrw: InsMemRW, regw: RegWre, ro: RegOut,
          wrd: WrRegData, srcb: ALUSrcB, aop: ALUOp, ext: ExtSel, m2r: ALUM2Reg,
          dmw: DataMemRW, psrc: PCSrc, ill: illegal};
    return v;
  endfunction

  // ALU-class instruction table: operation, B source, extender, destination register
  function automatic bit alu_lookup(input logic [5:0] op, output logic [2:0] aop,
                                    output logic srcb, output logic [1:0] ext, output logic [1:0] ro);
    srcb = 1'b0; ext = 2'b00; ro = 2'b10; aop = 3'b000;
    case (op)
      T_ADD:  aop = 3'b000;
      T_SUB:  aop = 3'b001;
      T_OR:   aop = 3'b011;
      T_AND:  aop = 3'b100;
      T_SLTU: aop = 3'b101;
      T_SLT:  aop = 3'b110;
      T_SLL:  begin aop = 3'b010; srcb = 1'b1; ext = 2'b00; end
      T_ADDI: begin aop = 3'b000; srcb = 1'b1; ext = 2'b10; ro = 2'b01; end
      T_ORI:  begin aop = 3'b011; srcb = 1'b1; ext = 2'b01; ro = 2'b01; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // expected per-cycle outputs for one instruction, starting at its fetch cycle
  function automatic void build(input logic [5:0] op, input logic z);
    vec_t v;
    logic [2:0] aop;
    logic srcb;
    logic [1:0] ext, ro;
    exp_q.delete();
    v = '0; v.st = 4'd0; v.irw = 1'b1; exp_q.push_back(v);
    v = '0; v.st = 4'd1;
    if (op == T_J || op == T_JR || op == T_JAL) begin
      v.pcw = 1'b1; v.psrc = (op == T_JR) ? 2'b10 : 2'b11;
      if (op == T_JAL) begin v.regw = 1'b1; v.ro = 2'b00; v.wrd = 1'b0; end
      exp_q.push_back(v);
    end else if (op == T_HALT) begin
      exp_q.push_back(v);
    end else if (op == T_BEQ) begin
      exp_q.push_back(v);
      v = '0; v.st = 4'd3; v.aop = 3'b001; v.ext = 2'b10; v.pcw = 1'b1;
      v.psrc = z ? 2'b01 : 2'b00;
      exp_q.push_back(v);
    end else if (op == T_LW || op == T_SW) begin
      exp_q.push_back(v);
      v = '0; v.st = 4'd4; v.srcb = 1'b1; v.ext = 2'b10; exp_q.push_back(v);
      v = '0; v.st = 4'd5;
      if (op == T_SW) begin
        v.dmw = 1'b1; v.pcw = 1'b1; exp_q.push_back(v);
      end else begin
        v.m2r = 1'b1; exp_q.push_back(v);
        v = '0; v.st = 4'd7; v.m2r = 1'b1; v.regw = 1'b1; v.wrd = 1'b1; v.ro = 2'b01; v.pcw = 1'b1;
        exp_q.push_back(v);
      end
    end else if (alu_lookup(op, aop, srcb, ext, ro)) begin
      exp_q.push_back(v);
      v = '0; v.st = 4'd2; v.aop = aop; v.srcb = srcb; v.ext = ext; exp_q.push_back(v);
      v.st = 4'd6; v.regw = 1'b1; v.wrd = 1'b1; v.ro = ro; v.pcw = 1'b1; exp_q.push_back(v);
    end else begin
      v.ill = 1'b1; v.pcw = 1'b1; exp_q.push_back(v);
    end
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return op == T_HALT;
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic z);
    int pc_cnt = 0;
    vec_t v;
    build(op, z);
    foreach (exp_q[i]) begin
      @(negedge clk);
      opcode = (i == 0) ? 6'($urandom) : op;
      zero = z;
      #1;
      v = observed();
      chk_eq($sformatf("op%b_cyc%0d", op, i), 32'(v), 32'(exp_q[i]));
      pc_cnt += int'(PCWre);
    end
    @(posedge clk);
    #1;
    chk_eq($sformatf("op%b_end_state", op), 32'(state), (op == T_HALT) ? 32'd8 : 32'd0);
    chk_eq($sformatf("op%b_pcwre_count", op), 32'(pc_cnt), (op == T_HALT) ? 32'd0 : 32'd1);
    if (op != T_HALT) n_inst++;
    $display("instr %0d op=%b zero=%b cycles=%0d", n_inst, op, z, exp_q.size());
  endtask

  task automatic reset_hold(input int cycles);
    vec_t zv;
    zv = '0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      opcode = (i[0]) ? T_SW : 6'($urandom);
      #1;
      chk_eq("reset_outputs", 32'(observed()), 32'(zv));
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    zv.irw = 1'b1;
    chk_eq("post_reset_if", 32'(observed()), 32'(zv));
    n_inst = 0;
    $display("reset released");
  endtask

  initial begin
    vec_t v;
    logic [5:0] op;
`ifdef MC_PERF_CNT_EN
    logic [31:0] frozen;
`endif
    #1 rst_n = 1'b0;
    reset_hold(3);

    run_instr(T_ADD, 1'b0);
    run_instr(T_LW, 1'b1);
    run_instr(T_SW, 1'b0);
    run_instr(T_BEQ, 1'b1);
    run_instr(T_BEQ, 1'b0);
    run_instr(T_JAL, 1'b0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 14)];
      end
      run_instr(op, 1'($urandom));
    end

    run_instr(6'b101010, 1'b0);
    run_instr(T_HALT, 1'b0);
`ifdef MC_PERF_CNT_EN
    frozen = cycle_cnt;
    chk_eq("inst_cnt", inst_cnt, 32'(n_inst));
`endif
    v = '0; v.st = 4'd8;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      opcode = 6'($urandom);
      zero = 1'($urandom);
      #1;
      chk_eq("halt_hold", 32'(observed()), 32'(v));
`ifdef MC_PERF_CNT_EN
      chk_eq("halt_cycle_cnt", cycle_cnt, frozen);
`endif
    end
    $display("halt held 20 cycles");

    // reset landing in the middle of a load, at its EXE_LS cycle
    #1 rst_n = 1'b0;
    reset_hold(1);
    build(T_LW, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      opcode = (i == 0) ? 6'($urandom) : T_LW;
      #1;
      chk_eq($sformatf("lw_abort_cyc%0d", i), 32'(observed()), 32'(exp_q[i]));
    end
    #1 rst_n = 1'b0;
    #1;
    chk_eq("abort_state", 32'(state), 32'd0);
    reset_hold(2);
    run_instr(T_ADD, 1'b0);
    run_instr(T_LW, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
